// File: rtl/fifo_tx_serializer_pkg.sv
// Shared definitions for the FIFO-to-serial-line transmit stage:
// FSM encoding, idle line level and counter width helper.
package fifo_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_DATA    = 3'd4,
        ST_STOP    = 3'd5
    } tx_state_e;

    localparam logic IDLE_LINE = 1'b1;

    // Counter width for a count range of n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_baud_tick_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous clear holds it at zero between frames.
module fifo_tx_serializer_baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    import fifo_tx_serializer_pkg::*;

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Bit-time counter with wrap at the terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == LAST_CNT) && !clr;

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from the synchronous FIFO and shifts each out as a serial frame:
// start bit, DATA_WIDTH data bits LSB first, stop bit.
module fifo_tx_serializer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    output logic                  fifo_rden_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_e             state_r;
    tx_state_e             state_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [BW-1:0]         bit_cnt_r;
    logic                  tx_r;
    logic                  baud_clr_s;
    logic                  baud_tick_s;

    // The bit clock only runs while a frame is on the line
    assign baud_clr_s = !((state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP));

    fifo_tx_serializer_baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr_s),
        .tick(baud_tick_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_i && !fifo_empty_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ:     state_s = ST_CAPTURE;
            ST_CAPTURE: state_s = ST_START;
            ST_START: begin
                if (baud_tick_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s && (bit_cnt_r == LAST_BIT)) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (baud_tick_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Shift register and bit counter; the FIFO word is only taken in CAPTURE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    shift_r   <= fifo_rdata_i;
                    bit_cnt_r <= '0;
                end
                ST_DATA: begin
                    if (baud_tick_s) begin
                        shift_r   <= shift_r >> 1;
                        bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? '0 : bit_cnt_r + 1'b1;
                    end
                end
                default: begin
                    shift_r   <= shift_r;
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

    // Registered line driver, one cycle behind the state it reflects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_r <= IDLE_LINE;
        end else begin
            case (state_r)
                ST_START: tx_r <= 1'b0;
                ST_DATA:  tx_r <= shift_r[0];
                default:  tx_r <= IDLE_LINE;
            endcase
        end
    end

    assign tx_o         = tx_r;
    assign fifo_rden_o  = (state_r == ST_REQ);
    assign busy_o       = (state_r != ST_IDLE);
    assign frame_done_o = (state_r == ST_STOP) && baud_tick_s;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Self-checking bench: FIFO model plus a line decoder comparing every frame
// against the queue of words expected on the wire.
module tb_fifo_tx_serializer;

    localparam int DW        = 8;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = (DW + 2) * CPB;
    localparam int SPACING   = 3 + (DW + 2) * CPB;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_rden;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_tx_serializer #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .fifo_empty_i(fifo_empty),
        .fifo_rdata_i(fifo_rdata),
        .fifo_rden_o (fifo_rden),
        .tx_o        (tx),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    int            n_total;
    int            n_bad;
    int            cyc;
    int            rden_cnt;
    int            rd_empty_err;
    int            rden_wide_err;
    int            fd_count;
    int            frames_seen;
    int            words_expected;
    logic          prev_rden;
    logic          mon_active;
    int            mon_idx;
    logic          mon_samp [0:FRAME_CYC-1];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            rden_times[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        words_expected++;
        fifo_empty = 1'b0;
    endtask

    // Decode a captured frame: every bit must hold CPB samples at one level.
    task automatic finish_frame();
        int            shape_err;
        logic [DW-1:0] word;
        shape_err = 0;
        word      = '0;
        for (int b = 0; b < DW + 2; b++) begin
            for (int k = 1; k < CPB; k++) begin
                if (mon_samp[b*CPB+k] !== mon_samp[b*CPB]) shape_err++;
            end
        end
        for (int b = 0; b < DW; b++) word[b] = mon_samp[(b+1)*CPB];
        chk("frame_shape", shape_err, 0);
        chk("stop_bit", mon_samp[(DW+1)*CPB], 1);
        if (exp_q.size() == 0) begin
            chk("frame_extra", 1, 0);
        end else begin
            chk("frame_word", word, exp_q.pop_front());
        end
        frames_seen++;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_active) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (t >= budget), 0);
    endtask

    task automatic wait_rden(input int budget);
        int t;
        int base;
        t    = 0;
        base = rden_cnt;
        while (rden_cnt == base && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("rden_timeout", (t >= budget), 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // FIFO read-port model: strobe seen during REQ, data valid for CAPTURE
    initial begin
        prev_rden = 1'b0;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) fd_count++;
            if (fifo_rden === 1'b1) begin
                rden_cnt++;
                rden_times.push_back(cyc);
                if (prev_rden) rden_wide_err++;
                if (fifo_q.size() == 0) begin
                    rd_empty_err++;
                end else begin
                    fifo_rdata <= fifo_q.pop_front();
                end
                fifo_empty = (fifo_q.size() == 0);
            end
            prev_rden = (fifo_rden === 1'b1);
        end
    end

    // Line monitor: a low level while idle starts a frame capture
    initial begin
        mon_active = 1'b0;
        mon_idx    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_idx    = 0;
                end
                if (mon_active) begin
                    mon_samp[mon_idx] = tx;
                    if (mon_idx == FRAME_CYC - 2) chk("done_pulse", frame_done, 1);
                    if (mon_idx == FRAME_CYC - 1) begin
                        chk("busy_end", busy, 0);
                        finish_frame();
                        mon_active = 1'b0;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        end
    end

    initial begin
        int            base;
        int            txlow;
        logic [DW-1:0] w;
        n_total        = 0;
        n_bad          = 0;
        rden_cnt       = 0;
        rd_empty_err   = 0;
        rden_wide_err  = 0;
        fd_count       = 0;
        frames_seen    = 0;
        words_expected = 0;
        rst            = 1'b1;
        enable         = 1'b0;
        fifo_empty     = 1'b1;
        fifo_rdata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_rden", fifo_rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;

        // single byte
        base = rden_cnt;
        push_word(8'hA5);
        enable = 1'b1;
        wait_drain(200);
        chk("single_rden", rden_cnt - base, 1);

        // empty hold-off
        base  = rden_cnt;
        txlow = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) txlow++;
        end
        chk("empty_rden", rden_cnt - base, 0);
        chk("empty_tx", txlow, 0);

        // back-to-back streaming
        enable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_word(DW'(i));
        rden_times.delete();
        enable = 1'b1;
        wait_drain(8 * SPACING + 100);
        chk("b2b_count", rden_times.size(), 8);
        for (int i = 1; i < rden_times.size(); i++) begin
            chk("b2b_spacing", rden_times[i] - rden_times[i-1], SPACING);
        end
        chk("b2b_fifo_left", fifo_q.size(), 0);

        // enable drop mid-frame
        enable = 1'b0;
        @(negedge clk);
        push_word(8'h3C);
        push_word(8'h55);
        enable = 1'b1;
        wait_rden(50);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        base   = rden_cnt;
        repeat (100) @(negedge clk);
        chk("endrop_rden", rden_cnt - base, 0);
        chk("endrop_pending", exp_q.size(), 1);
        enable = 1'b1;
        wait_drain(200);

        // reset during data bit 3
        enable = 1'b0;
        @(negedge clk);
        push_word(DW'($urandom));
        push_word(DW'($urandom));
        enable = 1'b1;
        wait_rden(50);
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_rden", fifo_rden, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", frame_done, 0);
        void'(exp_q.pop_front());
        words_expected--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_drain(200);

        // randomized pushes with enable toggling
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(2, 0)) push_word(DW'($urandom));
            enable = ($urandom_range(3, 0) != 0);
            repeat ($urandom_range(60, 1)) @(negedge clk);
        end
        enable = 1'b1;
        wait_drain(40 * SPACING);

        repeat (5) @(negedge clk);
        chk("rden_while_empty", rd_empty_err, 0);
        chk("rden_width", rden_wide_err, 0);
        chk("done_count", fd_count, frames_seen);
        chk("frame_count", frames_seen, words_expected);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
Downstream consumer for the team's synchronous FIFO. It pops one word at a time from the FIFO read port and shifts it out as an asynchronous serial frame: start bit, DATA_WIDTH data bits LSB first, then a stop bit. A programmable number of clocks sets each bit time. It is the FIFO-to-line stage of the serial transmit path.

Parameters:
DATA_WIDTH, 8, width of FIFO word and of the serial payload; must match the FIFO's DATA_WIDTH
CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable_i  input  1  when high, the block may start a new frame from IDLE
fifo_empty_i  input  1  FIFO empty_o
fifo_rdata_i  input  DATA_WIDTH  FIFO rdata_o; valid the cycle after a read strobe is sampled
fifo_rden_o  output  1  FIFO rden_i; single-cycle read strobe
tx_o  output  1  serial line; idle high
busy_o  output  1  high whenever the FSM is not in IDLE
frame_done_o  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (async, rst=1): state=IDLE, fifo_rden_o=0, tx_o=1, busy_o=0, frame_done_o=0. Baud counter, bit counter and shift register clear to 0.
- Outputs: tx_o is registered. fifo_rden_o is decoded from the registered state (state==REQ), so it is glitch-free and exactly one cycle wide.
- FSM states: IDLE, REQ, CAPTURE, START, DATA, STOP.
- IDLE: if enable_i=1 and fifo_empty_i=0 at a rising edge, go to REQ. Otherwise stay. tx_o=1.
- REQ (1 cycle): fifo_rden_o=1. The FIFO samples the strobe at the closing edge. Next state is CAPTURE.
- CAPTURE (1 cycle): fifo_rden_o=0. At the closing edge, load fifo_rdata_i into the shift register and clear the baud counter. Next state is START.
- START (CLKS_PER_BIT cycles): tx_o=0.
- DATA (DATA_WIDTH×CLKS_PER_BIT cycles): tx_o=shift[0]. Shift right once per bit time and increment the bit counter. Leave after bit DATA_WIDTH-1.
- STOP (CLKS_PER_BIT cycles): tx_o=1. frame_done_o=1 in the final cycle. Next state is IDLE.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; it counts 0..CLKS_PER_BIT-1, and its terminal count advances the bit or state. Bit counter is $clog2(DATA_WIDTH) bits, or 1 bit if DATA_WIDTH=1.
- tx_o timing: because tx_o is registered, each line bit appears one cycle after its state is entered. All bit widths are exactly CLKS_PER_BIT cycles.
- Throughput: consecutive rden pulses during continuous streaming are exactly 3 + (DATA_WIDTH+2)×CLKS_PER_BIT cycles apart (REQ + CAPTURE + frame + the IDLE decision cycle). For defaults that is 43 cycles.
- Empty: fifo_empty_i is sampled only in IDLE. The block never strobes rden while the FIFO is empty. Empty changing mid-frame has no effect.
- enable_i: sampled only in IDLE. Deasserting it mid-frame lets the current frame finish; no further read is issued.
- Reset mid-frame: tx_o returns high immediately. The in-flight word is discarded and not re-read. The FSM restarts in IDLE after rst falls.
- fifo_rdata_i is ignored in all states except CAPTURE.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE=0 … STOP=5, 3-bit).
  - IDLE_LINE=1'b1.
  - A clog2-based width helper constant for the counters.
- One natural sub-module, baud_tick_gen: a parameterised CLKS_PER_BIT counter with sync clear and a terminal-count tick output. The FSM, shift register and outputs stay in fifo_tx_serializer.

Test Plan:
1. Reset check: assert rst for 2 cycles mid-operation → tx_o=1, fifo_rden_o=0, busy_o=0 asynchronously; IDLE after release.
2. Single byte: FIFO preloaded with 0xA5, enable_i=1 → exactly one rden pulse; tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; frame_done_o pulses once; busy_o falls after the pulse.
3. Empty hold-off: fifo_empty_i=1, enable_i=1 for 50 cycles → fifo_rden_o stays 0 and tx_o stays 1.
4. Back-to-back: FIFO loaded with 0x00..0x07 via 8 writes → 8 rden pulses spaced 43 cycles apart; serial payloads decode to 0x00..0x07 in order; FIFO empty after the last frame.
5. Enable drop: deassert enable_i during the DATA bits of byte 0x3C → the 0x3C frame completes intact; no further rden while enable_i=0.
6. Reset mid-frame: assert rst during DATA bit 3 → tx_o high immediately; after release with the FIFO non-empty, the next frame carries the next FIFO word, not the aborted one.
